// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one DRAM port among NUM_REQ requesters
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module dram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      dram_req,
    output logic                      dram_we,
    output logic [ADDR_W-1:0]         dram_addr,
    output logic [DATA_W-1:0]         dram_wdata,
    input  logic                      dram_ready,
    input  logic [DATA_W-1:0]         dram_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                dram_req_q, dram_req_d;
    logic                dram_we_q, dram_we_d;
    logic [ADDR_W-1:0]   dram_addr_q, dram_addr_d;
    logic [DATA_W-1:0]   dram_wdata_q, dram_wdata_d;

    logic                found;
    logic [IDX_W-1:0]    win_idx;
    int                  cand;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Search starts one past the last winner so service rotates.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        done_d       = done_q;
        rdata_d      = rdata_q;
        dram_req_d   = dram_req_q;
        dram_we_d    = dram_we_q;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    dram_we_d    = req_we[win_idx];
                    dram_addr_d  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    dram_wdata_d = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                    gnt_d        = NUM_REQ'(1) << win_idx;
                    dram_req_d   = 1'b1;
                    ptr_d        = win_idx;
                    state_d      = ISSUE;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            ISSUE: begin
                if (dram_ready) begin
                    if (!dram_we_q) rdata_d = dram_rdata;
                    done_d     = gnt_q;
                    gnt_d      = '0;
                    dram_req_d = 1'b0;
                    state_d    = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                    done_d     = gnt_q;
                    err_d      = 1'b1;
                    gnt_d      = '0;
                    dram_req_d = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                done_d  = '0;
`ifdef ARB_TIMEOUT_EN
                err_d   = 1'b0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= IDX_W'(NUM_REQ-1);
            gnt_q        <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            dram_req_q   <= dram_req_d;
            dram_we_q    <= dram_we_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign dram_req   = dram_req_q;
    assign dram_we    = dram_we_q;
    assign dram_addr  = dram_addr_q;
    assign dram_wdata = dram_wdata_q;
`ifdef ARB_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - scoreboard bench for dram_arbiter (watchdog case under ARB_TIMEOUT_EN)
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  req_we = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic        dram_ready = 1'b0;
    logic [31:0] dram_rdata = '0;

    dram_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_ready(dram_ready), .dram_rdata(dram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_rdata = '0;
    logic [31:0] rd_val = '0;
    int          ready_delay = 0;
    int          wait_cnt = 0;
    logic        hang = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int who, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic e);
        exp_t x;
        x.who   = who;
        x.we    = we;
        x.addr  = addr;
        x.wdata = wdata;
        x.err   = e;
        x.rdata = (we || e) ? model_rdata : rd_val;
        model_rdata = x.rdata;
        sb.push_back(x);
    endtask

    // DRAM model: answers after ready_delay cycles of ISSUE unless hang is set.
    always @(posedge clk) begin
        #1;
        if (dram_ready) begin
            dram_ready = 1'b0;
            wait_cnt   = 0;
        end else if (dram_req && !hang) begin
            if (wait_cnt == ready_delay) begin
                dram_ready = 1'b1;
                dram_rdata = rd_val;
            end else begin
                wait_cnt++;
            end
        end else if (!dram_req) begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (gnt != 2'b00) chk("gnt_onehot", 64'($onehot(gnt)), 64'd1);
            if (dram_req) begin
                if (sb.size() == 0) chk("dram_req_unexpected", 64'(dram_req), 64'd0);
                else begin
                    chk("dram_addr", 64'(dram_addr), 64'(sb[0].addr));
                    chk("dram_we", 64'(dram_we), 64'(sb[0].we));
                    if (sb[0].we) chk("dram_wdata", 64'(dram_wdata), 64'(sb[0].wdata));
                    chk("gnt_owner", 64'(gnt), 64'(2'b01 << sb[0].who));
                end
            end
            if (done != 2'b00) begin
                if (sb.size() == 0) chk("spurious_done", 64'(done), 64'd0);
                else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("done_owner", 64'(done), 64'(2'b01 << x.who));
                    chk("rdata", 64'(rdata), 64'(x.rdata));
                    chk("err", 64'(err), 64'(x.err));
                    chk("gnt_at_done", 64'(gnt), 64'd0);
                end
            end
        end
    end

    task automatic wait_req_done(input int i, input int budget);
        int n;
        n = 0;
        while (!done[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done[i]) chk("done_wait_expired", 64'd0, 64'd1);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic wait_dram_req(input int budget);
        int n;
        n = 0;
        while (!dram_req && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!dram_req) chk("dram_req_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic serve_twice(input int i);
        for (int n = 0; n < 2; n++) begin
            wait_req_done(i, 100);
            if (n == 0) begin
                @(posedge clk); #1;
                req[i] = 1'b1;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dram_req", 64'(dram_req), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);

        // single read, ready on third ISSUE cycle
        rd_val = 32'hDEAD_BEEF;
        ready_delay = 2;
        req_addr[31:0] = 32'h0000_0040;
        req_we = 2'b00;
        push_exp(0, 1'b0, 32'h40, 32'h0, 1'b0);
        req[0] = 1'b1;
        wait_req_done(0, 50);
        repeat (3) @(posedge clk);
        #1 chk("rdata_hold", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

        // write; requester inputs change mid-transaction and must be ignored
        rd_val = 32'hCAFE_F00D;
        ready_delay = 3;
        req_we[1] = 1'b1;
        req_addr[63:32] = 32'h0000_0080;
        req_wdata[63:32] = 32'h1234_5678;
        push_exp(1, 1'b1, 32'h80, 32'h1234_5678, 1'b0);
        req[1] = 1'b1;
        wait_dram_req(20);
        req_wdata[63:32] = 32'h0;
        req_addr[63:32] = 32'hFFFF_FFFF;
        req_we[1] = 1'b0;
        wait_req_done(1, 50);
        repeat (2) @(posedge clk);
        #1 chk("rdata_after_write", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

        // contention with immediate ready: order 0,1,0,1
        rd_val = 32'h0BAD_C0DE;
        ready_delay = 0;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_we = 2'b00;
        push_exp(0, 1'b0, 32'h100, 32'h0, 1'b0);
        push_exp(1, 1'b0, 32'h200, 32'h0, 1'b0);
        push_exp(0, 1'b0, 32'h100, 32'h0, 1'b0);
        push_exp(1, 1'b0, 32'h200, 32'h0, 1'b0);
        @(posedge clk); #1;
        req = 2'b11;
        fork
            serve_twice(0);
            serve_twice(1);
        join
        repeat (3) @(posedge clk);
        #1 chk("contention_drained", 64'(sb.size()), 64'd0);

        // reset while a transaction hangs in ISSUE
        hang = 1'b1;
        req_addr[31:0] = 32'h0000_0300;
        push_exp(0, 1'b0, 32'h300, 32'h0, 1'b0);
        req = 2'b01;
        wait_dram_req(20);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b00;
        @(posedge clk); #1;
        chk("midrst_dram_req", 64'(dram_req), 64'd0);
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_rdata", 64'(rdata), 64'd0);
        sb.delete();
        model_rdata = '0;
        hang = 1'b0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd_val = 32'h5555_AAAA;
        ready_delay = 1;
        req_addr = {32'h0000_0500, 32'h0000_0400};
        push_exp(0, 1'b0, 32'h400, 32'h0, 1'b0);
        push_exp(1, 1'b0, 32'h500, 32'h0, 1'b0);
        req = 2'b11;
        fork
            wait_req_done(0, 50);
            wait_req_done(1, 100);
        join
        repeat (3) @(posedge clk);
        #1 chk("post_reset_drained", 64'(sb.size()), 64'd0);

`ifdef ARB_TIMEOUT_EN
        begin
            int cyc;
            hang = 1'b1;
            req_addr[31:0] = 32'h0000_0600;
            push_exp(0, 1'b0, 32'h600, 32'h0, 1'b1);
            req = 2'b01;
            wait_dram_req(20);
            cyc = 0;
            while (!done[0] && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("timeout_latency", 64'(cyc), 64'd8);
            chk("timeout_err", 64'(err), 64'd1);
            @(posedge clk); #1;
            req = 2'b00;
            hang = 1'b0;
            repeat (3) @(posedge clk);
            #1 chk("timeout_rdata", 64'(rdata), 64'h0000_0000_5555_AAAA);
        end
`else
        hang = 1'b1;
        req_addr[63:32] = 32'h0000_0700;
        push_exp(1, 1'b0, 32'h700, 32'h0, 1'b0);
        req = 2'b10;
        wait_dram_req(20);
        repeat (20) @(posedge clk);
        #1;
        chk("hang_dram_req", 64'(dram_req), 64'd1);
        chk("hang_err", 64'(err), 64'd0);
        chk("hang_done", 64'(done), 64'd0);
        rst = 1'b0;
        req = 2'b00;
        @(posedge clk); #1;
        sb.delete();
        model_rdata = '0;
        hang = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("hang_cleared", 64'(dram_req), 64'd0);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
